// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and helpers for the HDMI frame reader
package hdmi_pkg;

    localparam int PIXEL_W = 24;
    localparam int REMAIN_W = 22;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DONE
    } rd_state_e;

    localparam pixel_t BLACK_PIXEL = '0;

    // Length of the next burst: the remaining pixel count clipped to the burst limit.
    function automatic logic [7:0] burst_len(input logic [REMAIN_W-1:0] remain,
                                             input int unsigned max_len);
        if (remain < REMAIN_W'(max_len)) begin
            return remain[7:0];
        end
        return 8'(max_len);
    endfunction

endpackage

// File: rtl/hdmi_pix_fifo.sv
// rtl/hdmi_pix_fifo.sv - single-clock pixel FIFO with synchronous flush and registered read
module hdmi_pix_fifo
    import hdmi_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count == '0);
    assign do_wr = wr_en && !flush && (count != (AW+1)'(DEPTH));
    assign do_rd = rd_en && !flush && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A read on an empty FIFO presents black rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= empty ? DATA_W'(BLACK_PIXEL) : mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_frame_reader.sv
// rtl/hdmi_frame_reader.sv - burst-fetches one RGB frame from the frame store into a pixel FIFO
module hdmi_frame_reader
    import hdmi_pkg::*;
#(
    parameter int          DATA_W     = 24,
    parameter int          ADDR_W     = 22,
    parameter int          FIFO_DEPTH = 1024,
    parameter int          BURST_LEN  = 128,
    parameter int unsigned FRAME_BASE = 0
) (
    input  logic              hdmi_clk,
    input  logic              rst_n,
    input  logic              video_vs,
    input  logic [10:0]       h_disp,
    input  logic [10:0]       v_disp,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [7:0]        mem_rd_len,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              underflow,
    output logic              frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state;
    rd_state_e             state_nxt;
    logic                  vs_d;
    logic                  frame_start;
    logic [ADDR_W-1:0]     addr;
    logic [REMAIN_W-1:0]   remain;
    logic [REMAIN_W-1:0]   pend_total;
    logic [REMAIN_W-1:0]   frame_total;
    logic [REMAIN_W-1:0]   reload_total;
    logic [7:0]            beats;
    logic [7:0]            len_q;
    logic                  req_q;
    logic                  restart_pend;
    logic                  underflow_q;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_free;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  ack_now;
    logic                  beat_ok;
    logic                  final_beat;
    logic                  defer;
    logic                  reload;
    logic                  issue;

    assign frame_start = vs_d && !video_vs;
    assign frame_total = REMAIN_W'(h_disp) * REMAIN_W'(v_disp);
    assign fifo_free   = CW'(FIFO_DEPTH) - fifo_count;

    assign mem_rd_req  = req_q;
    assign mem_rd_addr = addr;
    assign mem_rd_len  = len_q;
    assign underflow   = underflow_q;
    assign frame_done  = final_beat && !restart_pend && (remain == '0);

    // An accepted burst is never abandoned: a frame start that lands on it is deferred
    // until its last beat, so the memory side always sees every burst run to completion.
    always_comb begin
        ack_now      = req_q && mem_rd_ack;
        beat_ok      = (state == RECV) && mem_rd_valid;
        final_beat   = beat_ok && (beats == 8'd1);
        defer        = frame_start && (((state == RECV) && !final_beat) || ack_now);
        reload       = (frame_start && !defer) || (restart_pend && final_beat);
        reload_total = frame_start ? frame_total : pend_total;
        fifo_wr      = beat_ok && !restart_pend;
        issue        = (state == REQ) && !req_q && (remain != '0) &&
                       (fifo_free >= CW'(BURST_LEN)) && !frame_start;
        state_nxt    = state;
        if (reload) begin
            state_nxt = (reload_total == '0) ? DONE : REQ;
        end else begin
            case (state)
                REQ:     if (ack_now) state_nxt = RECV;
                RECV:    if (final_beat) state_nxt = (remain != '0) ? REQ : DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d         <= 1'b0;
            addr         <= ADDR_W'(FRAME_BASE);
            remain       <= '0;
            pend_total   <= '0;
            beats        <= '0;
            len_q        <= '0;
            req_q        <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            vs_d <= video_vs;
            if (reload) begin
                addr         <= ADDR_W'(FRAME_BASE);
                remain       <= reload_total;
                req_q        <= 1'b0;
                restart_pend <= 1'b0;
                beats        <= '0;
            end else begin
                if (defer) begin
                    restart_pend <= 1'b1;
                    pend_total   <= frame_total;
                end
                if (ack_now) begin
                    req_q  <= 1'b0;
                    addr   <= addr + ADDR_W'(len_q);
                    remain <= remain - REMAIN_W'(len_q);
                    beats  <= len_q;
                end else begin
                    if (issue) begin
                        req_q <= 1'b1;
                        len_q <= burst_len(remain, BURST_LEN);
                    end
                    if (beat_ok) begin
                        beats <= beats - 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge hdmi_clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (frame_start) begin
            underflow_q <= 1'b0;
        end else if (rd_en && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end

    hdmi_pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (hdmi_clk),
        .rst_n   (rst_n),
        .flush   (reload),
        .wr_en   (fifo_wr),
        .wr_data (mem_rd_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

endmodule
